// File: rtl/share_buf_arbiter_if.sv
// -----------------------------------------------------------------------------
// share_buf_arbiter_if
//   Bundles the requester-side burst handshake and the shared buffer SRAM
//   strobes of share_buf_arbiter into one interface.
//   modport slave  : the arbiter (samples requests and SRAM read data, drives
//                    grants, beat/done/rvalid/rid and the SRAM strobes)
//   modport master : the environment (requesters plus the SRAM model)
//   Signals:
//     req, req_wr        per-requester request level / write flag
//     req_addr, req_len  packed per-requester start address / length-1
//     req_wdata          packed per-requester write data of current beat
//     gnt, done          one-hot grant / last-beat pulse
//     beat               a beat is issued to the SRAM this cycle
//     rvalid, rid        read data valid and the requester owning it
//     share_*            SRAM port (cen/wen active-low, ren active-high)
// -----------------------------------------------------------------------------
interface share_buf_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 13,
    parameter int DW   = 16,
    parameter int LW   = 4
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic               beat;
    logic [NREQ-1:0]    done;
    logic               rvalid;
    logic [2:0]         rid;
    logic               share_cen;
    logic               share_wen;
    logic               share_ren;
    logic [AW-1:0]      share_addr;
    logic [DW-1:0]      share_wdata;
    logic [DW-1:0]      share_rdata;

    modport slave (
        input  req, req_wr, req_addr, req_len, req_wdata, share_rdata,
        output gnt, beat, done, rvalid, rid,
               share_cen, share_wen, share_ren, share_addr, share_wdata
    );

    modport master (
        output req, req_wr, req_addr, req_len, req_wdata, share_rdata,
        input  gnt, beat, done, rvalid, rid,
               share_cen, share_wen, share_ren, share_addr, share_wdata
    );
endinterface

// File: rtl/share_buf_arbiter.sv
// -----------------------------------------------------------------------------
// share_buf_arbiter
//   Round-robin burst arbiter for the single-port shared buffer SRAM. Each
//   grant is a burst of 1..2**LW consecutive-address beats, read or write.
//   Arbitration happens only in IDLE, so one idle SRAM cycle always separates
//   two bursts. The pointer moves past the last winner when its burst ends.
//   Ports:
//     CLK    clock, rising edge
//     RESET  asynchronous, active-low reset
//     bus    share_buf_arbiter_if.slave (requester handshake + SRAM port)
// -----------------------------------------------------------------------------
module share_buf_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 13,
    parameter int DW   = 16,
    parameter int LW   = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    share_buf_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [IW-1:0] ptr;     // highest-priority requester for the next arbitration
    logic [IW-1:0] owner;   // requester holding the current burst
    logic          wr;
    logic [LW-1:0] len;
    logic [LW-1:0] cnt;     // index of the beat currently on the SRAM port
    logic [IW-1:0] win;
    logic          last;

    // First asserted request at or after p, searched cyclically.
    function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r,
                                           input logic [IW-1:0]   p);
        logic [IW-1:0] w;
        logic          found;
        int            j;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(p) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && r[IW'(j)]) begin
                w     = IW'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win  = pick(bus.req, ptr);
    assign last = (state == BURST) && (cnt == len);

    // Write data is taken live from the owner so the requester can stream it.
    assign bus.share_wdata = bus.req_wdata[int'(owner)*DW +: DW];
    assign bus.done        = last ? bus.gnt : '0;

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            wr             <= 1'b0;
            len            <= '0;
            cnt            <= '0;
            bus.gnt        <= '0;
            bus.beat       <= 1'b0;
            bus.rvalid     <= 1'b0;
            bus.rid        <= '0;
            bus.share_cen  <= 1'b1;
            bus.share_wen  <= 1'b1;
            bus.share_ren  <= 1'b0;
            bus.share_addr <= '0;
        end else begin
            // Read data returns one cycle after its beat, so tag it here.
            bus.rvalid <= bus.beat & ~wr;
            bus.rid    <= 3'(owner);

            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state          <= BURST;
                        owner          <= win;
                        wr             <= bus.req_wr[win];
                        len            <= bus.req_len[int'(win)*LW +: LW];
                        cnt            <= '0;
                        bus.gnt        <= '0;
                        bus.gnt[win]   <= 1'b1;
                        bus.beat       <= 1'b1;
                        bus.share_cen  <= 1'b0;
                        bus.share_wen  <= ~bus.req_wr[win];
                        bus.share_ren  <= 1'b1;
                        bus.share_addr <= bus.req_addr[int'(win)*AW +: AW];
                    end
                end
                BURST: begin
                    if (cnt == len) begin
                        state         <= IDLE;
                        bus.gnt       <= '0;
                        bus.beat      <= 1'b0;
                        bus.share_cen <= 1'b1;
                        bus.share_wen <= 1'b1;
                        bus.share_ren <= 1'b0;
                        ptr           <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                    end else begin
                        cnt            <= cnt + LW'(1);
                        // Address wraps naturally at 2**AW.
                        bus.share_addr <= bus.share_addr + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_share_buf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_share_buf_arbiter
//   Directed bench for share_buf_arbiter. A transaction-level model turns each
//   grant into a schedule of beat slots plus one idle slot; a compare process
//   checks the DUT against the slot at the head of that schedule every cycle.
//   Literal expectations in the stimulus pin the model itself.
// -----------------------------------------------------------------------------
module tb_share_buf_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 13;
    localparam int DW   = 16;
    localparam int LW   = 4;

    logic CLK;
    logic RESET;

    share_buf_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) bus ();

    share_buf_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    assign bus.share_rdata = 16'h5A5A;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            owner;   // -1 = no beat on the SRAM port
        logic          wr;
        logic [AW-1:0] addr;
        bit            last;
    } slot_t;

    slot_t sched[$];
    slot_t cur;
    slot_t idle_slot;
    int    m_ptr;
    bit    exp_rvalid;
    int    exp_rid;
    int    m_win;
    int    m_base;
    int    m_len;

    initial begin
        idle_slot = '{owner: -1, wr: 1'b0, addr: '0, last: 1'b0};
        cur       = idle_slot;
        m_ptr     = 0;
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) begin
                sched.delete();
                cur        = idle_slot;
                m_ptr      = 0;
                exp_rvalid = 1'b0;
                exp_rid    = 0;
            end else begin
                exp_rvalid = (cur.owner >= 0) && !cur.wr;
                if (cur.owner >= 0) exp_rid = cur.owner;
                if (sched.size() == 0 && bus.req != '0) begin
                    m_win = -1;
                    for (int k = 0; k < NREQ; k++)
                        if (m_win < 0 && bus.req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
                    m_base = int'(bus.req_addr[m_win*AW +: AW]);
                    m_len  = int'(bus.req_len[m_win*LW +: LW]);
                    for (int b = 0; b <= m_len; b++)
                        sched.push_back('{owner: m_win, wr: bus.req_wr[m_win],
                                          addr: AW'((m_base + b) % (1 << AW)),
                                          last: (b == m_len)});
                    sched.push_back(idle_slot);
                    m_ptr = (m_win + 1) % NREQ;
                end
                if (sched.size() != 0) cur = sched.pop_front();
                else                   cur = idle_slot;
            end
        end
    end

    // ---------------- compare process ----------------
    logic [NREQ-1:0] exp_gnt;
    logic            exp_beat;

    initial forever begin
        @(negedge CLK);
        exp_beat = (cur.owner >= 0);
        exp_gnt  = '0;
        if (exp_beat) exp_gnt[cur.owner] = 1'b1;
        check("gnt",    32'(bus.gnt),       32'(exp_gnt));
        check("beat",   32'(bus.beat),      32'(exp_beat));
        check("done",   32'(bus.done),      cur.last ? 32'(exp_gnt) : 32'd0);
        check("cen",    32'(bus.share_cen), 32'(!exp_beat));
        check("wen",    32'(bus.share_wen), exp_beat ? 32'(!cur.wr) : 32'd1);
        check("ren",    32'(bus.share_ren), 32'(exp_beat));
        check("rvalid", 32'(bus.rvalid),    32'(exp_rvalid));
        if (exp_rvalid) check("rid", 32'(bus.rid), 32'(exp_rid));
        if (exp_beat) begin
            check("addr", 32'(bus.share_addr), 32'(cur.addr));
            if (cur.wr)
                check("wdata", 32'(bus.share_wdata), 32'(bus.req_wdata[cur.owner*DW +: DW]));
        end
    end

    // ---------------- write data streams ----------------
    int wbase[NREQ];
    int wcnt[NREQ];

    initial forever begin
        @(negedge CLK);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.beat && bus.gnt[i]) wcnt[i]++;
            bus.req_wdata[i*DW +: DW] = DW'(wbase[i] + wcnt[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(negedge CLK);
    endtask

    task automatic put(input int i, input bit wr, input int addr, input int len, input int wd);
        bus.req_wr[i]             = wr;
        bus.req_addr[i*AW +: AW]  = AW'(addr);
        bus.req_len[i*LW +: LW]   = LW'(len);
        wbase[i]                  = wd;
        wcnt[i]                   = 0;
        bus.req[i]                = 1'b1;
    endtask

    logic [NREQ-1:0] rr_seq [10];
    int              addr4  [4];
    int              n0;
    int              first3;

    initial begin
        rr_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        addr4  = '{8190, 8191, 0, 1};
        RESET         = 1'b0;
        bus.req       = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            wbase[i] = 16'h1000 * i;
            wcnt[i]  = 0;
        end
        repeat (2) nxt();
        check("rst_addr", 32'(bus.share_addr), 32'd0);
        check("rst_rid",  32'(bus.rid),        32'd0);
        check("rst_cen",  32'(bus.share_cen),  32'd1);
        #1 RESET = 1'b1;
        nxt();

        // 1: requester 1 writes 4 beats at 100
        #1 put(1, 1'b1, 100, 3, 16'hA0);
        nxt();
        check("t1_gnt",   32'(bus.gnt),         32'b0010);
        check("t1_wen",   32'(bus.share_wen),   32'd0);
        check("t1_addr0", 32'(bus.share_addr),  32'd100);
        check("t1_wd0",   32'(bus.share_wdata), 32'hA0);
        #1 bus.req[1] = 1'b0;
        for (int b = 1; b < 4; b++) begin
            nxt();
            check("t1_addr", 32'(bus.share_addr),  32'(100 + b));
            check("t1_wd",   32'(bus.share_wdata), 32'(16'hA0 + b));
            check("t1_done", 32'(bus.done),        (b == 3) ? 32'b0010 : 32'd0);
        end
        nxt();
        check("t1_cen_off", 32'(bus.share_cen), 32'd1);

        // 2: requester 2 reads 2 beats at 200
        #1 put(2, 1'b0, 200, 1, 0);
        nxt();
        check("t2_wen",  32'(bus.share_wen),  32'd1);
        check("t2_ren",  32'(bus.share_ren),  32'd1);
        check("t2_addr", 32'(bus.share_addr), 32'd200);
        #1 bus.req[2] = 1'b0;
        nxt();
        check("t2_done", 32'(bus.done),   32'b0100);
        check("t2_rv1",  32'(bus.rvalid), 32'd1);
        check("t2_rid",  32'(bus.rid),    32'd2);
        nxt();
        check("t2_rv2",  32'(bus.rvalid), 32'd1);
        nxt();
        check("t2_rv3",  32'(bus.rvalid), 32'd0);

        // 3: all requesters, single-beat reads, from a fresh pointer
        #1 RESET = 1'b0;
        nxt();
        #1 RESET = 1'b1;
        for (int i = 0; i < NREQ; i++) put(i, 1'b0, 300 + i, 0, 0);
        for (int c = 0; c < 10; c++) begin
            nxt();
            check("t3_rr", 32'(bus.gnt), 32'(rr_seq[c]));
        end
        #1 bus.req = '0;

        // 4: address wrap
        put(0, 1'b1, 8190, 3, 16'h0400);
        for (int b = 0; b < 4; b++) begin
            nxt();
            check("t4_addr", 32'(bus.share_addr), 32'(addr4[b]));
            if (b == 0) #1 bus.req[0] = 1'b0;
        end
        nxt();

        // 5: req3 arrives mid-burst, req0 drops mid-burst
        #1 put(0, 1'b1, 40, 5, 16'h0500);
        n0     = 0;
        first3 = -1;
        for (int c = 0; c < 12; c++) begin
            nxt();
            if (bus.gnt == 4'b0001) n0++;
            if (bus.gnt == 4'b1000 && first3 < 0) begin
                first3 = c;
                #1 bus.req[3] = 1'b0;
            end
            if (c == 1) #1 put(3, 1'b0, 60, 0, 0);
            if (c == 2) #1 bus.req[0] = 1'b0;
        end
        check("t5_beats0", 32'(n0),     32'd6);
        check("t5_slot3",  32'(first3), 32'd7);

        // 6: reset in the middle of a 16-beat burst
        #1 put(2, 1'b1, 500, 15, 16'h0600);
        repeat (3) nxt();
        check("t6_gnt_b2", 32'(bus.gnt), 32'b0100);
        #1 RESET = 1'b0;
        #1;
        check("t6_cen",  32'(bus.share_cen), 32'd1);
        check("t6_gnt",  32'(bus.gnt),       32'd0);
        check("t6_done", 32'(bus.done),      32'd0);
        check("t6_beat", 32'(bus.beat),      32'd0);
        bus.req[2] = 1'b0;
        nxt();
        #1 RESET = 1'b1;
        put(1, 1'b0, 10, 0, 0);
        put(0, 1'b0, 20, 0, 0);
        nxt();
        check("t6_win", 32'(bus.gnt), 32'b0001);
        #1 bus.req = '0;
        repeat (3) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
